// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer.
// Pulses the board PLL reset, waits for lock within a timeout, qualifies the
// lock over a stability window and only then releases the system reset.
// While running, it watches for loss of lock (filtered against short
// glitches) and re-runs the whole sequence on loss or on request.
// Single clock domain: the free-running 50 MHz reference clock.

`timescale 1ns/1ps

module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_FILTER   = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic [1:0] state,
    output logic [7:0] relock_cnt,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Terminal counts of the shared phase counter, one per state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           st;
    state_t           st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lock_m;
    logic             lock_s;
    logic             relock_req;
    logic             timeout_hit;
    logic             pll_rst_nxt;
    logic             sys_rst_n_nxt;
    logic [7:0]       relock_cnt_nxt;
    logic             timeout_err_nxt;

    // Two-flop synchroniser bringing the asynchronous lock flag into refclk.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make lock_s take the old lock_m,
            // giving a true two-stage pipeline; blocking would collapse it.
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    // State register plus all registered outputs, loaded from next-state values.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            st          <= RESET_PLL;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            relock_cnt  <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            st          <= st_nxt;
            cnt         <= cnt_nxt;
            pll_rst     <= pll_rst_nxt;
            sys_rst_n   <= sys_rst_n_nxt;
            relock_cnt  <= relock_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    // Next-state and phase-counter logic; every transition clears the counter.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        st_nxt      = st;
        cnt_nxt     = cnt;
        relock_req  = 1'b0;
        timeout_hit = 1'b0;
        unique case (st)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    st_nxt  = WAIT_LOCK;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing in the same cycle.
                if (lock_s) begin
                    st_nxt  = STABLE;
                    cnt_nxt = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    st_nxt      = RESET_PLL;
                    cnt_nxt     = '0;
                    timeout_hit = 1'b1;
                    relock_req  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE: begin
                // A dropout restarts the lock wait, but is neither a timeout nor a relock.
                if (!lock_s) begin
                    st_nxt  = WAIT_LOCK;
                    cnt_nxt = '0;
                end else if (cnt == STABLE_LAST) begin
                    st_nxt  = RUN;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            RUN: begin
                // Counter tracks consecutive unlocked cycles; loss and request share one exit.
                if (force_relock || (!lock_s && (cnt == LOSS_LAST))) begin
                    st_nxt     = RESET_PLL;
                    cnt_nxt    = '0;
                    relock_req = 1'b1;
                end else if (lock_s) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        endcase
    end

    // Output decode from the next state so outputs switch on the same edge as state.
    always_comb begin
        pll_rst_nxt     = (st_nxt == RESET_PLL);
        sys_rst_n_nxt   = (st_nxt == RUN);
        relock_cnt_nxt  = relock_cnt;
        if (relock_req && (relock_cnt != 8'hFF)) begin
            relock_cnt_nxt = relock_cnt + 8'd1;
        end
        timeout_err_nxt = timeout_err | timeout_hit;
    end

    assign state = st;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer.
// A table of constant-input segments (inputs, cycle count, expected outputs
// after the last edge) is applied in order; each segment pushes its expected
// outputs to a scoreboard queue when driven and pops/compares them once the
// DUT has clocked through. A hand-written loop covers relock saturation and a
// mid-sequence reset.

`timescale 1ns/1ps

module tb_pll_reset_sequencer;

    localparam int unsigned RST_CYCLES    = 4;
    localparam int unsigned LOCK_TIMEOUT  = 20;
    localparam int unsigned STABLE_CYCLES = 8;
    localparam int unsigned LOSS_FILTER   = 3;
    localparam int unsigned CNT_W         = 16;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [1:0] state;
    logic [7:0] relock_cnt;
    logic       timeout_err;

    typedef struct {
        logic       rst_n;
        logic       locked;
        logic       force_r;
        int         cycles;
        logic [1:0] st;
        logic       pll_rst;
        logic       sys_rst_n;
        logic [7:0] relock;
        logic       terr;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       pll_rst;
        logic       sys_rst_n;
        logic [7:0] relock;
        logic       terr;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOSS_FILTER  (LOSS_FILTER),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .state       (state),
        .relock_cnt  (relock_cnt),
        .timeout_err (timeout_err)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic add(input logic r, input logic lk, input logic fr, input int cyc,
                       input logic [1:0] st, input logic prst, input logic srst,
                       input logic [7:0] rc, input logic te);
        vec_t v;
        v.rst_n = r; v.locked = lk; v.force_r = fr; v.cycles = cyc;
        v.st = st; v.pll_rst = prst; v.sys_rst_n = srst; v.relock = rc; v.terr = te;
        vecs.push_back(v);
    endtask

    // Drive one segment, push its expectation, clock it through, pop and compare.
    task automatic run_seg(input string tag, input vec_t v);
        exp_t e;
        rst_n        = v.rst_n;
        pll_locked   = v.locked;
        force_relock = v.force_r;
        e.st = v.st; e.pll_rst = v.pll_rst; e.sys_rst_n = v.sys_rst_n;
        e.relock = v.relock; e.terr = v.terr;
        exp_q.push_back(e);
        repeat (v.cycles) @(posedge refclk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".state"},       int'(state),       int'(e.st));
            check({tag, ".pll_rst"},     int'(pll_rst),     int'(e.pll_rst));
            check({tag, ".sys_rst_n"},   int'(sys_rst_n),   int'(e.sys_rst_n));
            check({tag, ".relock_cnt"},  int'(relock_cnt),  int'(e.relock));
            check({tag, ".timeout_err"}, int'(timeout_err), int'(e.terr));
        end
        force_relock = 1'b0;
    endtask

    task automatic seg(input string tag, input logic r, input logic lk, input logic fr,
                       input int cyc, input logic [1:0] st, input logic prst,
                       input logic srst, input logic [7:0] rc, input logic te);
        vec_t v;
        v.rst_n = r; v.locked = lk; v.force_r = fr; v.cycles = cyc;
        v.st = st; v.pll_rst = prst; v.sys_rst_n = srst; v.relock = rc; v.terr = te;
        run_seg(tag, v);
    endtask

    initial begin
        // rst_n lk  fr  cyc  st  prst srst rc te
        // Reset values.
        add(1'b0, 1'b0, 1'b0, 2, 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        // Bring-up: 4 cycles of pll_rst, lock appears as WAIT_LOCK is entered,
        // WAIT_LOCK lasts 2 cycles, STABLE lasts 8 cycles, then RUN.
        add(1'b1, 1'b0, 1'b0, 3, 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 7, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1, 2'd3, 1'b0, 1'b1, 8'd0, 1'b0);
        // RUN: 2-cycle glitch is filtered out.
        add(1'b1, 1'b0, 1'b0, 2, 2'd3, 1'b0, 1'b1, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4, 2'd3, 1'b0, 1'b1, 8'd0, 1'b0);
        // RUN: sustained loss exits on the 3rd synced-low cycle.
        add(1'b1, 1'b0, 1'b0, 4, 2'd3, 1'b0, 1'b1, 8'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b0, 8'd1, 1'b0);
        // No lock: 20-cycle WAIT_LOCK windows, force_relock ignored in WAIT_LOCK.
        add(1'b1, 1'b0, 1'b0, 3, 2'd0, 1'b1, 1'b0, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 5, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 13, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b0, 8'd2, 1'b1);
        add(1'b1, 1'b0, 1'b0, 23, 2'd1, 1'b0, 1'b0, 8'd2, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b0, 8'd3, 1'b1);
        // STABLE dropout seen at cnt=5: back to WAIT_LOCK, full window restarts.
        add(1'b1, 1'b0, 1'b0, 3, 2'd0, 1'b1, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 3, 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1, 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 7, 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd3, 1'b0, 1'b1, 8'd3, 1'b1);
        // Loss and force_relock in the same cycle: one transition, one increment.
        add(1'b1, 1'b0, 1'b0, 4, 2'd3, 1'b0, 1'b1, 8'd3, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1, 2'd0, 1'b1, 1'b0, 8'd4, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b0, 8'd4, 1'b1);
        // Back to RUN (sync already settled), then a lone force_relock.
        add(1'b1, 1'b1, 1'b0, 2, 2'd0, 1'b1, 1'b0, 8'd4, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd4, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b0, 8'd4, 1'b1);
        add(1'b1, 1'b1, 1'b0, 7, 2'd2, 1'b0, 1'b0, 8'd4, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1, 2'd3, 1'b0, 1'b1, 8'd4, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1, 2'd0, 1'b1, 1'b0, 8'd5, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_seg($sformatf("vec%0d", i), vecs[i]);
        end

        // 300 forced relocks from RUN: relock_cnt climbs from 5 and saturates at 255.
        for (int i = 0; i < 300; i++) begin
            int unsigned rc_run;
            int unsigned rc_rst;
            rc_run = (5 + i > 255) ? 255 : 5 + i;
            rc_rst = (6 + i > 255) ? 255 : 6 + i;
            seg($sformatf("sat%0d.run", i), 1'b1, 1'b1, 1'b0, 13, 2'd3, 1'b0, 1'b1,
                8'(rc_run), 1'b1);
            seg($sformatf("sat%0d.force", i), 1'b1, 1'b1, 1'b1, 1, 2'd0, 1'b1, 1'b0,
                8'(rc_rst), 1'b1);
        end

        // Reset asserted mid-STABLE: everything back to reset values on the next edge.
        seg("mid.stable", 1'b1, 1'b1, 1'b0, 6, 2'd2, 1'b0, 1'b0, 8'd255, 1'b1);
        seg("mid.reset",  1'b0, 1'b1, 1'b0, 1, 2'd0, 1'b1, 1'b0, 8'd0,   1'b0);

        // Synchroniser was cleared by reset: with lock held high, bring-up still
        // takes 4 cycles of pll_rst, and WAIT_LOCK exits one cycle after entry.
        seg("post.rst",  1'b1, 1'b1, 1'b0, 3, 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        seg("post.wait", 1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
        seg("post.stab", 1'b1, 1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
